// File: rtl/pim_job_dispatcher.sv
// Round-robin dot-product job dispatcher for the PIM lanes.
// Job k always maps to lane k mod P, so results are returned strictly in job order.
module pim_job_dispatcher #(
    parameter int WIDTH     = 16,
    parameter int MAX_SIZE  = 4,
    parameter int NUM_PIMS  = 4,
    parameter int ACC_WIDTH = 2*WIDTH + $clog2(MAX_SIZE),
    parameter int IDX_W     = $clog2(MAX_SIZE*MAX_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [2:0]                    size,
    input  logic [2:0]                    no_of_pims,
    output logic                          busy,
    output logic                          done,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [MAX_SIZE*WIDTH-1:0]     op_a,
    input  logic [MAX_SIZE*WIDTH-1:0]     op_b,
    output logic [NUM_PIMS-1:0]           pim_valid,
    input  logic [NUM_PIMS-1:0]           pim_ready,
    output logic [MAX_SIZE*WIDTH-1:0]     pim_a,
    output logic [MAX_SIZE*WIDTH-1:0]     pim_b,
    input  logic [NUM_PIMS-1:0]           pim_res_valid,
    input  logic [NUM_PIMS*ACC_WIDTH-1:0] pim_res,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACC_WIDTH-1:0]          res_data,
    output logic [IDX_W-1:0]              res_index
);
    localparam int CNT_W = IDX_W + 1;
    localparam int PTR_W = (NUM_PIMS > 1) ? $clog2(NUM_PIMS) : 1;
    localparam int PW    = ($clog2(NUM_PIMS+1) > 3) ? $clog2(NUM_PIMS+1) : 3;
    localparam int VW    = MAX_SIZE*WIDTH;
    localparam int unsigned NMAX = (MAX_SIZE > 7) ? 7 : MAX_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    logic [2:0]           r_n;
    logic [PTR_W-1:0]     r_p_last;
    logic [PTR_W-1:0]     r_disp_ptr;
    logic [PTR_W-1:0]     r_ret_ptr;
    logic [CNT_W-1:0]     r_disp_cnt;
    logic [CNT_W-1:0]     r_ret_cnt;
    logic [NUM_PIMS-1:0]  r_out;
    logic [NUM_PIMS-1:0]  r_full;
    logic [NUM_PIMS-1:0]  r_pim_valid;
    logic [ACC_WIDTH-1:0] r_res [NUM_PIMS];
    logic [VW-1:0]        r_pim_a;
    logic [VW-1:0]        r_pim_b;
    logic                 r_busy;
    logic                 r_done;

    logic [CNT_W-1:0]     w_total;
    logic [2:0]           w_n_start;
    logic [PW-1:0]        w_p_start;
    logic [VW-1:0]        w_mask_a;
    logic [VW-1:0]        w_mask_b;
    logic                 w_op_ready;
    logic                 w_op_hs;
    logic                 w_res_hs;

    assign w_total   = CNT_W'(r_n) * CNT_W'(r_n);
    assign w_n_start = (size > 3'(NMAX)) ? 3'(NMAX) : size;
    assign w_p_start = (no_of_pims == 3'd0 || PW'(no_of_pims) > PW'(NUM_PIMS))
                       ? PW'(NUM_PIMS) : PW'(no_of_pims);

    // One job in flight on the shared operand bus at a time; the target lane must be empty.
    assign w_op_ready = (r_state == S_RUN) && (r_disp_cnt < w_total)
                        && !r_out[r_disp_ptr] && !(|r_pim_valid);
    assign w_op_hs    = op_valid && w_op_ready;
    assign w_res_hs   = r_full[r_ret_ptr] && res_ready;

    always_comb begin
        w_mask_a = op_a;
        w_mask_b = op_b;
        for (int unsigned i = 0; i < MAX_SIZE; i++) begin
            if (i >= 32'(r_n)) begin
                w_mask_a[i*WIDTH +: WIDTH] = '0;
                w_mask_b[i*WIDTH +: WIDTH] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_p_last    <= '0;
            r_disp_ptr  <= '0;
            r_ret_ptr   <= '0;
            r_disp_cnt  <= '0;
            r_ret_cnt   <= '0;
            r_out       <= '0;
            r_full      <= '0;
            r_pim_valid <= '0;
            r_pim_a     <= '0;
            r_pim_b     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int unsigned i = 0; i < NUM_PIMS; i++) r_res[i] <= '0;
        end else begin
            if (|(r_pim_valid & pim_ready)) r_pim_valid <= '0;

            if (w_op_hs) begin
                r_pim_valid             <= '0;
                r_pim_valid[r_disp_ptr] <= 1'b1;
                r_pim_a                 <= w_mask_a;
                r_pim_b                 <= w_mask_b;
                r_out[r_disp_ptr]       <= 1'b1;
                r_disp_ptr              <= (r_disp_ptr == r_p_last) ? '0 : r_disp_ptr + 1'b1;
                r_disp_cnt              <= r_disp_cnt + 1'b1;
            end

            for (int unsigned i = 0; i < NUM_PIMS; i++) begin
                if (pim_res_valid[i] && r_out[i] && !r_full[i]) begin
                    r_res[i]  <= pim_res[i*ACC_WIDTH +: ACC_WIDTH];
                    r_full[i] <= 1'b1;
                end
            end

            // Returning lane is full, so neither capture nor dispatch can touch it this cycle.
            if (w_res_hs) begin
                r_full[r_ret_ptr] <= 1'b0;
                r_out[r_ret_ptr]  <= 1'b0;
                r_ret_ptr         <= (r_ret_ptr == r_p_last) ? '0 : r_ret_ptr + 1'b1;
                r_ret_cnt         <= r_ret_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_n         <= w_n_start;
                        r_p_last    <= PTR_W'(w_p_start - PW'(1));
                        r_busy      <= 1'b1;
                        r_disp_ptr  <= '0;
                        r_ret_ptr   <= '0;
                        r_disp_cnt  <= '0;
                        r_ret_cnt   <= '0;
                        r_out       <= '0;
                        r_full      <= '0;
                        r_pim_valid <= '0;
                    end
                end
                S_RUN: begin
                    if (r_ret_cnt == w_total) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign op_ready  = w_op_ready;
    assign pim_valid = r_pim_valid;
    assign pim_a     = r_pim_a;
    assign pim_b     = r_pim_b;
    assign res_valid = r_full[r_ret_ptr];
    assign res_data  = r_res[r_ret_ptr];
    assign res_index = r_ret_cnt[IDX_W-1:0];

endmodule

// File: tb/tb_pim_job_dispatcher.sv
// Directed bench for pim_job_dispatcher: lane model with per-lane latency, in-order result checks.
module tb_pim_job_dispatcher;
    localparam int WIDTH     = 16;
    localparam int MAX_SIZE  = 4;
    localparam int NUM_PIMS  = 4;
    localparam int ACC_WIDTH = 34;
    localparam int IDX_W     = 4;
    localparam int VW        = MAX_SIZE*WIDTH;

    logic                          clk;
    logic                          rst;
    logic                          start;
    logic [2:0]                    size;
    logic [2:0]                    no_of_pims;
    logic                          busy;
    logic                          done;
    logic                          op_valid;
    logic                          op_ready;
    logic [VW-1:0]                 op_a;
    logic [VW-1:0]                 op_b;
    logic [NUM_PIMS-1:0]           pim_valid;
    logic [NUM_PIMS-1:0]           pim_ready;
    logic [VW-1:0]                 pim_a;
    logic [VW-1:0]                 pim_b;
    logic [NUM_PIMS-1:0]           pim_res_valid;
    logic [NUM_PIMS*ACC_WIDTH-1:0] pim_res;
    logic                          res_valid;
    logic                          res_ready;
    logic [ACC_WIDTH-1:0]          res_data;
    logic [IDX_W-1:0]              res_index;

    pim_job_dispatcher #(
        .WIDTH(WIDTH), .MAX_SIZE(MAX_SIZE), .NUM_PIMS(NUM_PIMS),
        .ACC_WIDTH(ACC_WIDTH), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .no_of_pims(no_of_pims),
        .busy(busy), .done(done), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .pim_valid(pim_valid), .pim_ready(pim_ready),
        .pim_a(pim_a), .pim_b(pim_b), .pim_res_valid(pim_res_valid), .pim_res(pim_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_index(res_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0]          ma [4][4];
    logic [15:0]          mb [4][4];
    logic [ACC_WIDTH-1:0] exp_res [16];
    int                   lat [4];
    int                   cnt [4];
    logic [ACC_WIDTH-1:0] lres [4];
    int                   pjob;
    int                   cur_n;
    int                   cur_p;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] vec_a(input int k, input int n, input logic [15:0] fill);
        logic [VW-1:0] v;
        int r;
        r = k / n;
        for (int i = 0; i < MAX_SIZE; i++) v[i*16 +: 16] = (i < n) ? ma[r][i] : fill;
        return v;
    endfunction

    function automatic logic [VW-1:0] vec_b(input int k, input int n, input logic [15:0] fill);
        logic [VW-1:0] v;
        int c;
        c = k % n;
        for (int i = 0; i < MAX_SIZE; i++) v[i*16 +: 16] = (i < n) ? mb[i][c] : fill;
        return v;
    endfunction

    task automatic set_mats(input int kind);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 16'd0;
                mb[r][c] = 16'd0;
            end
        for (int k = 0; k < 16; k++) exp_res[k] = '0;
        case (kind)
            0: begin
                ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
                mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
                exp_res[0] = 19; exp_res[1] = 22; exp_res[2] = 43; exp_res[3] = 50;
            end
            1: begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        ma[r][c] = (r == c) ? 16'd1 : 16'd0;
                        mb[r][c] = 16'(r*3 + c + 1);
                    end
                for (int k = 0; k < 9; k++) exp_res[k] = ACC_WIDTH'(k + 1);
            end
            2: begin
                ma[0][0] = 2; ma[0][1] = 3; ma[1][0] = 4; ma[1][1] = 5;
                mb[0][0] = 6; mb[0][1] = 7; mb[1][0] = 8; mb[1][1] = 9;
                exp_res[0] = 36; exp_res[1] = 41; exp_res[2] = 64; exp_res[3] = 73;
            end
            default: begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        ma[r][c] = (r == c) ? 16'd1 : 16'd0;
                        mb[r][c] = 16'(r*4 + c + 10);
                    end
                for (int k = 0; k < 16; k++) exp_res[k] = ACC_WIDTH'(k + 10);
            end
        endcase
    endtask

    // PIM lanes: accept on pim_valid&pim_ready, pulse the dot product lat[i] cycles later.
    task automatic lane_model();
        logic [ACC_WIDTH-1:0] acc;
        pim_res_valid = '0;
        for (int i = 0; i < NUM_PIMS; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    pim_res_valid[i] = 1'b1;
                    pim_res[i*ACC_WIDTH +: ACC_WIDTH] = lres[i];
                end
            end
        end
        for (int i = 0; i < NUM_PIMS; i++) begin
            if (pim_valid[i] && pim_ready[i]) begin
                chk("disp_lane", 64'(i), 64'(pjob % cur_p));
                chk("pim_a", pim_a, vec_a(pjob, cur_n, 16'h0000));
                chk("pim_b", pim_b, vec_b(pjob, cur_n, 16'h0000));
                acc = '0;
                for (int j = 0; j < MAX_SIZE; j++)
                    acc += ACC_WIDTH'(pim_a[j*16 +: 16]) * ACC_WIDTH'(pim_b[j*16 +: 16]);
                lres[i] = acc;
                cnt[i]  = lat[i];
                pjob++;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_op_ready"}, 64'(op_ready), 0);
        chk({tag, "_pim_valid"}, 64'(pim_valid), 0);
        chk({tag, "_pim_a"}, pim_a, 0);
        chk({tag, "_pim_b"}, pim_b, 0);
        chk({tag, "_res_valid"}, 64'(res_valid), 0);
        chk({tag, "_res_data"}, 64'(res_data), 0);
        chk({tag, "_res_index"}, 64'(res_index), 0);
    endtask

    task automatic run_cmd(input logic [2:0] sz, input logic [2:0] np, input int n, input int p,
                           input int stall, input bit glitch, input bit ooo);
        int jobs, feed, ret, ndone, post;
        bit hs, seen_done, chk_next, first_fire;
        jobs = n*n; feed = 0; ret = 0; ndone = 0; post = 0;
        hs = 0; seen_done = 0; chk_next = 0; first_fire = 0;
        cur_n = n; cur_p = p; pjob = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        @(negedge clk);
        start = 1'b1; size = sz; no_of_pims = np; op_valid = 1'b0; res_ready = 1'b1;
        for (int cyc = 0; cyc < 600 && post < 4; cyc++) begin
            @(negedge clk);
            start = glitch && (cyc == 3);
            size  = (glitch && cyc == 3) ? 3'd3 : sz;
            lane_model();
            if (chk_next) begin
                chk("ooo_hold_res_valid", 64'(res_valid), 0);
                chk_next = 0;
            end
            if (ooo && !first_fire && |pim_res_valid) begin
                first_fire = 1;
                chk("ooo_first_lane", 64'(pim_res_valid), 64'h2);
                chk_next = 1;
            end
            if (hs) feed++;
            if (feed < jobs) begin
                op_valid = 1'b1;
                op_a = vec_a(feed, n, 16'hFFFF);
                op_b = vec_b(feed, n, 16'hFFFF);
            end else begin
                op_valid = 1'b0;
            end
            hs = op_valid && op_ready;
            res_ready = (cyc >= stall);
            if (stall > 0 && cyc == stall - 1) begin
                chk("bp_op_ready", 64'(op_ready), 0);
                chk("bp_res_valid", 64'(res_valid), 1);
                chk("bp_res_index", 64'(res_index), 0);
                chk("bp_res_data", 64'(res_data), 64'(exp_res[0]));
            end
            if (res_valid && res_ready) begin
                chk("res_index", 64'(res_index), 64'(ret));
                chk("res_data", 64'(res_data), (ret < 16) ? 64'(exp_res[ret]) : '1);
                ret++;
            end
            if (seen_done) post++;
            if (done) begin
                ndone++;
                if (!seen_done) chk("busy_at_done", 64'(busy), 0);
                seen_done = 1;
            end
        end
        chk("done_seen", 64'(seen_done), 1);
        chk("done_count", 64'(ndone), 1);
        chk("jobs_fed", 64'(feed), 64'(jobs));
        chk("jobs_returned", 64'(ret), 64'(jobs));
        chk("jobs_dispatched", 64'(pjob), 64'(jobs));
        chk("idle_busy", 64'(busy), 0);
        chk("idle_op_ready", 64'(op_ready), 0);
        op_valid = 1'b0;
        pim_res_valid = '0;
        res_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; size = '0; no_of_pims = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; pim_ready = '1;
        pim_res_valid = '0; pim_res = '0; res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin lat[i] = 3; cnt[i] = 0; end
        repeat (3) @(negedge clk);
        check_zero("por");
        rst = 1'b0;

        // Reset in the middle of a command, then a stray result right after reset.
        set_mats(0);
        cur_n = 2; cur_p = 2;
        @(negedge clk);
        start = 1'b1; size = 3'd2; no_of_pims = 3'd2;
        @(negedge clk);
        start = 1'b0; op_valid = 1'b1;
        op_a = vec_a(0, 2, 16'hFFFF); op_b = vec_b(0, 2, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("mid_busy", 64'(busy), 1);
        rst = 1'b1; op_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("rst_mid");
        rst = 1'b0;
        pim_res_valid = 4'b0001; pim_res[ACC_WIDTH-1:0] = 34'd123;
        @(negedge clk);
        pim_res_valid = '0;
        @(negedge clk);
        chk("post_rst_res_valid", 64'(res_valid), 0);
        chk("post_rst_busy", 64'(busy), 0);

        set_mats(0);
        run_cmd(3'd2, 3'd2, 2, 2, 0, 1'b0, 1'b0);
        run_cmd(3'd2, 3'd2, 2, 2, 10, 1'b0, 1'b0);
        run_cmd(3'd2, 3'd1, 2, 1, 0, 1'b1, 1'b0);

        set_mats(1);
        lat[0] = 8; lat[1] = 1; lat[2] = 2; lat[3] = 3;
        run_cmd(3'd3, 3'd3, 3, 3, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) lat[i] = 3;

        set_mats(2);
        run_cmd(3'd2, 3'd7, 2, 4, 0, 1'b0, 1'b0);

        set_mats(3);
        run_cmd(3'd6, 3'd0, 4, 4, 0, 1'b0, 1'b0);

        // size 0: RUN then DONE with no handshakes.
        @(negedge clk);
        start = 1'b1; size = 3'd0; no_of_pims = 3'd2;
        @(negedge clk);
        start = 1'b0;
        chk("n0_busy_c1", 64'(busy), 1);
        chk("n0_done_c1", 64'(done), 0);
        chk("n0_op_ready_c1", 64'(op_ready), 0);
        @(negedge clk);
        chk("n0_done_c2", 64'(done), 1);
        chk("n0_busy_c2", 64'(busy), 0);
        chk("n0_op_ready_c2", 64'(op_ready), 0);
        @(negedge clk);
        chk("n0_done_c3", 64'(done), 0);

        // Stray result pulse on an idle lane.
        pim_res_valid = 4'b0100;
        pim_res[2*ACC_WIDTH +: ACC_WIDTH] = 34'd999;
        @(negedge clk);
        pim_res_valid = '0;
        chk("spur_res_valid_a", 64'(res_valid), 0);
        @(negedge clk);
        chk("spur_res_valid_b", 64'(res_valid), 0);
        chk("spur_busy", 64'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pim_job_dispatcher.md
Name: pim_job_dispatcher

Overview:
Sits between the memory front-end and the PIM array. The front-end streams one dot-product job per handshake: a row of A and a column of B. The block dispatches jobs round-robin to the active PIM lanes and captures each lane's result. Results are returned to memory write-back strictly in job order, with the job index attached.

Parameters:
WIDTH, 16, element width in bits
MAX_SIZE, 4, max matrix dimension N (>=2); job vector length
NUM_PIMS, 4, physical PIM lanes
ACC_WIDTH, 2*WIDTH+$clog2(MAX_SIZE), dot-product result width
IDX_W, $clog2(MAX_SIZE*MAX_SIZE), job index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  command strobe; sampled in IDLE only
size  in  3  N; jobs = N*N
no_of_pims  in  3  active lanes
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last result returned
op_valid  in  1  job operands valid
op_ready  out  1  job accepted when op_valid&&op_ready
op_a  in  MAX_SIZE*WIDTH  row vector, element i at [i*WIDTH+:WIDTH]
op_b  in  MAX_SIZE*WIDTH  column vector, same packing
pim_valid  out  NUM_PIMS  one-hot job request to lane
pim_ready  in  NUM_PIMS  lane accepts job
pim_a  out  MAX_SIZE*WIDTH  shared operand bus to lanes
pim_b  out  MAX_SIZE*WIDTH  shared operand bus to lanes
pim_res_valid  in  NUM_PIMS  one-cycle result pulse per lane
pim_res  in  NUM_PIMS*ACC_WIDTH  lane i result at [i*ACC_WIDTH+:ACC_WIDTH]
res_valid  out  1  in-order result valid
res_ready  in  1  write-back accepts result
res_data  out  ACC_WIDTH  result
res_index  out  IDX_W  job index (row*N+col)

Behaviour:
- Reset values: every output is 0. All lane state, pointers, counters and result registers are cleared.
- Reset mid-operation: aborts the command and returns to IDLE. Any pim_res_valid in the cycle after reset is ignored.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. On entry, latch N = min(size, MAX_SIZE) and P = no_of_pims. If P is 0 or greater than NUM_PIMS, use P = NUM_PIMS. Set busy=1 and clear the dispatch, return and lane pointers.
  - RUN -> DONE when returned count == N*N.
  - DONE: done=1 for exactly one cycle, busy drops the same cycle, then IDLE.
  - start while busy is ignored.
  - N==0 goes IDLE -> RUN -> DONE with no handshakes; done pulses 2 cycles after start.
- Lane state: each lane holds at most one job. It is either outstanding (job sent, awaiting result) or full (result captured, not yet returned).
- Dispatch rules:
  - op_ready = RUN && dispatched<N*N && lane[disp_ptr] not outstanding && no pim_valid pending.
  - On an op handshake in cycle t, from t+1: pim_valid[disp_ptr]=1, pim_a/pim_b = registered operands with elements at index>=N forced to 0. Set outstanding[disp_ptr]=1. disp_ptr = (disp_ptr+1) mod P. dispatched++.
  - pim_valid and the operand buses hold until pim_ready of that lane is sampled high. pim_valid clears the following cycle.
- Result capture:
  - pim_res_valid[i] with outstanding[i]=1 and full[i]=0: capture pim_res slice into res_reg[i], set full[i]=1.
  - Any other pim_res_valid is ignored, including on inactive lanes.
- Return path:
  - res_valid = full[ret_ptr]; res_data = res_reg[ret_ptr]; res_index = returned count.
  - On res_valid&&res_ready: clear full and outstanding for that lane, ret_ptr = (ret_ptr+1) mod P, returned++.
  - A lane freed in cycle t is dispatchable from t+1; there is no same-cycle bypass.
  - res_data and res_index stay stable while res_valid is high and res_ready is low.
- Ordering: job k always maps to lane k mod P, so results leave in index order regardless of lane completion order.
- Arithmetic: counters are IDX_W+1 bits wide. Pointers wrap at P, not at NUM_PIMS.

Test Plan:
1. Reset: assert rst 2 cycles mid-stream -> all outputs 0, busy 0; next start runs a full clean command.
2. Basic flow: N=2, P=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], lane model latency 3 -> res_data 19,22,43,50 with res_index 0..3; single done pulse; busy falls with done.
3. Out-of-order completion: N=3, P=3, lane 1 returns before lane 0 -> lane 1 result held; results still emitted with res_index 0,1,2,...,8 in order.
4. Backpressure: N=2, P=2, res_ready low 10 cycles -> op_ready low once both lanes are outstanding; resumes after release; no result lost or duplicated.
5. Masking and clamping: size=2, op_a elements 2,3 = 16'hFFFF -> pim_a elements 2,3 = 0. size=6 runs 16 jobs (N clamped to 4). no_of_pims=0 uses 4 lanes.
6. Edge cases: start while busy ignored; size=0 -> done 2 cycles after start, no op_ready; spurious pim_res_valid on an idle lane -> no res_valid.
